c_pipeline_arbiter: RTL and testbench

//  Synchronous controller sharing one Muller-C handshake pipeline (muller_c chain) among N_REQ requesters.

---
 rtl/c_pipeline_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_c_pipeline_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c_pipeline_arbiter.sv
// c_pipeline_arbiter
//   Shares one Muller-C handshake pipeline among N_REQ clocked requesters.
//   A round-robin injector launches tokens by toggling pipe_req (2-phase),
//   a sink drains tokens at the far end by echoing pipe_ackn onto pipe_sink,
//   and an id FIFO returns the requester id of each completing token.
//   Both asynchronous pipeline outputs enter through SYNC_STAGES flops.
//
//   Optional feature macro: PIPE_ARB_TIMEOUT_EN
//     defined   -> stage-0 acceptance watchdog (TIMEOUT cycles), sticky err_o,
//                  terminal FAULT state; the TIMEOUT parameter exists only here
//     undefined -> WAIT waits indefinitely, err_o is constant 0
//
//   Injector states
//     state   | meaning
//     --------+-----------------------------------------------------------
//     S_IDLE  | no token being offered; waits for a request and FIFO room
//     S_ARB   | one cycle: pick winner, grant, toggle pipe_req, push id
//     S_WAIT  | token offered; waits for stage 0 to echo pipe_req
//     S_FAULT | stage 0 never accepted (timeout build only); held to reset
module c_pipeline_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DEPTH       = 3,
`ifdef PIPE_ARB_TIMEOUT_EN
    parameter int TIMEOUT     = 64,
`endif
    parameter int SYNC_STAGES = 2,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             pipe_r,
    output logic             pipe_req,
    input  logic             pipe_ack0,
    input  logic             pipe_ackn,
    output logic             pipe_sink,
    output logic             done_o,
    output logic [IW-1:0]    done_id_o,
    output logic [CW-1:0]    inflight_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [IW-1:0] ID_LAST = IW'(N_REQ - 1);

`ifdef PIPE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT} state_t;
`endif

    state_t state, state_nx;

    logic                   pipe_r_q;
    logic [SYNC_STAGES-1:0] a0_sync;
    logic [SYNC_STAGES-1:0] an_sync;
    logic                   a0s;
    logic                   ans;

    logic                   req_q;
    logic                   sink_q;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          winner;
    logic                   win_valid;

    logic [IW-1:0]          fifo_mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   push;
    logic                   pop;

    // FIFO pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Pipeline reset held for the reset cycles plus one cycle after release,
    // so the C-elements are clear before the first token is offered
    always_ff @(posedge clk) begin
        if (reset) pipe_r_q <= 1'b1;
        else       pipe_r_q <= 1'b0;
    end

    assign pipe_r = reset | pipe_r_q;

    // Synchronise the two asynchronous pipeline outputs into clk
    always_ff @(posedge clk) begin
        if (reset) begin
            a0_sync <= '0;
            an_sync <= '0;
        end else begin
            a0_sync <= {a0_sync[SYNC_STAGES-2:0], pipe_ack0};
            an_sync <= {an_sync[SYNC_STAGES-2:0], pipe_ackn};
        end
    end

    assign a0s = a0_sync[SYNC_STAGES-1];
    assign ans = an_sync[SYNC_STAGES-1];

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win last.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        win_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_i[IW'(idx)]) begin
                winner    = IW'(idx);
                win_valid = 1'b1;
            end
        end
    end

`ifdef PIPE_ARB_TIMEOUT_EN
    logic [TW-1:0] tmr;
    logic          err_q;
`endif

    // Injector next-state and grant decode
    always_comb begin
        state_nx = state;
        grant_o  = '0;
        push     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((|req_i) && (count < DEPTH_C) && !pipe_r_q) state_nx = S_ARB;
            end
            S_ARB: begin
                // Requests may have dropped since IDLE; no winner means no token
                if (win_valid) begin
                    grant_o  = N_REQ'(1) << winner;
                    push     = 1'b1;
                    state_nx = S_WAIT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                if (a0s == req_q) state_nx = S_IDLE;
`ifdef PIPE_ARB_TIMEOUT_EN
                else if (tmr == '0) state_nx = S_FAULT;
`endif
            end
`ifdef PIPE_ARB_TIMEOUT_EN
            S_FAULT: state_nx = S_FAULT;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Injector state, 2-phase request toggle and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            rr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (push) begin
                req_q  <= ~req_q;
                rr_ptr <= (winner == ID_LAST) ? '0 : winner + IW'(1);
            end
        end
    end

    // A sink edge with no token outstanding is spurious and left untouched
    assign pop = (ans != sink_q) && (count != '0);

    // Id storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= winner;
    end

    // Sink echo, completion reporting and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            sink_q    <= 1'b0;
            done_o    <= 1'b0;
            done_id_o <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            done_o <= pop;
            if (pop) begin
                sink_q    <= ans;
                done_id_o <= fifo_mem[rd_ptr];
                rd_ptr    <= ptr_inc(rd_ptr);
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_ARB_TIMEOUT_EN
    // Acceptance watchdog: loaded as WAIT is entered, counts down while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (push)                                tmr <= TW'(TIMEOUT - 1);
            else if (state == S_WAIT && tmr != '0)   tmr <= tmr - TW'(1);
            if (state == S_WAIT && state_nx == S_FAULT) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign pipe_req   = req_q;
    assign pipe_sink  = sink_q;
    assign inflight_o = count;
    assign busy_o     = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_c_pipeline_arbiter.sv
// Bench for c_pipeline_arbiter (default build, 4 requesters, depth 3).
// A behavioural asynchronous pipeline drives pipe_ack0/pipe_ackn; a reference
// model keeps the expected round-robin pointer, the queue of outstanding ids
// and the expected pipe_req phase, and checks the DUT every cycle.
module tb_c_pipeline_arbiter;
    localparam int N_REQ = 4;
    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_i = '0;
    logic [3:0] grant_o;
    logic       pipe_r, pipe_req, pipe_sink, done_o, busy_o, err_o;
    logic       pipe_ack0 = 1'b0;
    logic       pipe_ackn = 1'b0;
    logic [1:0] done_id_o;
    logic [1:0] inflight_o;

    always #5 clk = ~clk;

    c_pipeline_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .grant_o(grant_o),
        .pipe_r(pipe_r), .pipe_req(pipe_req), .pipe_ack0(pipe_ack0),
        .pipe_ackn(pipe_ackn), .pipe_sink(pipe_sink), .done_o(done_o),
        .done_id_o(done_id_o), .inflight_o(inflight_o), .busy_o(busy_o),
        .err_o(err_o)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  n;
        logic [31:0] ids;   // expected grant ids, one hex digit each, first grant in the low digit
    } vec_t;

    vec_t vecs [6];

    int  n_chk = 0;
    int  n_pass = 0;
    int  mq[$];          // ids of tokens the model believes are in flight
    int  vexp[$];        // expected grant ids of the current directed vector
    int  mrr = 0;
    bit  par = 1'b0;
    int  gcount = 0;
    logic [3:0] last_grant = '0;
    int  ptok[$];        // pipeline model: remaining travel time per token
    int  d0 = 0;
    bit  stall = 1'b0;
    bit  gen_new = 1'b0;
    bit  auto_clear = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < N_REQ; k++)
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return -1;
    endfunction

    task automatic monitor();
        int w;
        int gid;
        int e;
        logic [3:0] eg;
        last_grant = grant_o;
        if (reset) return;
        if (done_o) begin
            chk(mq.size() != 0, "done_with_token", int'(done_id_o), -1);
            if (mq.size() != 0) begin
                w = mq.pop_front();
                chk(int'(done_id_o) == w, "done_id", int'(done_id_o), w);
            end
        end
        chk(int'(inflight_o) == mq.size(), "inflight", int'(inflight_o), mq.size());
        chk(pipe_req == par, "pipe_req", int'(pipe_req), int'(par));
        chk(err_o == 1'b0, "err", int'(err_o), 0);
        if (mq.size() != 0) chk(busy_o == 1'b1, "busy", int'(busy_o), 1);
        if (grant_o != '0) begin
            w  = rr_winner(req_i, mrr);
            eg = (w < 0) ? 4'b0000 : 4'(1 << w);
            chk(grant_o == eg, "grant", int'(grant_o), int'(eg));
            chk(mq.size() < DEPTH, "grant_room", mq.size(), DEPTH - 1);
            gid = 0;
            for (int i = 0; i < N_REQ; i++) if (grant_o[i]) gid = i;
            if (vexp.size() != 0) begin
                e = vexp.pop_front();
                chk(gid == e, "vec_id", gid, e);
            end
            if (w >= 0) begin
                mq.push_back(w);
                mrr = (w + 1) % N_REQ;
            end else begin
                mq.push_back(gid);
            end
            par = ~par;
            gcount++;
        end
    endtask

    // Asynchronous pipeline abstraction: stage 0 echoes pipe_req after a
    // short delay, tokens travel a few cycles, and the last stage toggles
    // pipe_ackn only once the sink has echoed the previous token.
    task automatic pipe_model();
        if (pipe_r) begin
            pipe_ack0 = 1'b0;
            pipe_ackn = 1'b0;
            ptok.delete();
            d0 = 0;
            return;
        end
        for (int i = 0; i < ptok.size(); i++) if (ptok[i] > 0) ptok[i]--;
        if (pipe_req != pipe_ack0) begin
            if (d0 > 0) d0--;
            else begin
                pipe_ack0 = pipe_req;
                ptok.push_back(int'($urandom_range(0, 4)));
                d0 = int'($urandom_range(0, 2));
            end
        end
        if (!stall && ptok.size() > 0 && ptok[0] == 0 && pipe_ackn == pipe_sink) begin
            pipe_ackn = ~pipe_ackn;
            ptok.delete(0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        pipe_model();
        if (auto_clear) req_i = req_i & ~last_grant;
        if (gen_new) begin
            for (int i = 0; i < N_REQ; i++)
                if (!req_i[i] && $urandom_range(0, 3) == 0) req_i[i] = 1'b1;
            if ($urandom_range(0, 49) == 0) stall = ~stall;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_i = '0;
        stall = 1'b0;
        mq.delete();
        vexp.delete();
        par = 1'b0;
        mrr = 0;
        repeat (2) step();
        chk(grant_o == 4'b0, "rst_grant", int'(grant_o), 0);
        chk(done_o == 1'b0, "rst_done", int'(done_o), 0);
        chk(done_id_o == 2'd0, "rst_done_id", int'(done_id_o), 0);
        chk(inflight_o == 2'd0, "rst_inflight", int'(inflight_o), 0);
        chk(pipe_req == 1'b0, "rst_pipe_req", int'(pipe_req), 0);
        chk(pipe_sink == 1'b0, "rst_pipe_sink", int'(pipe_sink), 0);
        chk(busy_o == 1'b0, "rst_busy", int'(busy_o), 0);
        chk(err_o == 1'b0, "rst_err", int'(err_o), 0);
        chk(pipe_r == 1'b1, "rst_pipe_r", int'(pipe_r), 1);
        reset = 1'b0;
        @(negedge clk);
        chk(pipe_r == 1'b1, "pipe_r_hold", int'(pipe_r), 1);
        @(posedge clk);
        #1;
        pipe_model();
        @(negedge clk);
        chk(pipe_r == 1'b0, "pipe_r_release", int'(pipe_r), 0);
        @(posedge clk);
        #1;
        pipe_model();
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 400 && (mq.size() != 0 || req_i != '0); c++) step();
        chk(mq.size() == 0, name, mq.size(), 0);
    endtask

    task automatic run_vec(input logic [3:0] r, input int n, input logic [31:0] ids);
        int g0;
        vexp.delete();
        for (int k = 0; k < n; k++) vexp.push_back(int'((ids >> (4 * k)) & 32'hF));
        g0 = gcount;
        req_i = r;
        for (int c = 0; c < 600 && (gcount - g0) < n; c++) step();
        req_i = '0;
        chk((gcount - g0) == n, "vec_grants", gcount - g0, n);
        drain("vec_drain");
    endtask

    initial begin
        int g0;
        logic s0;
        vecs[0] = '{req: 4'b1111, n: 4'd8, ids: 32'h3210_3210};
        vecs[1] = '{req: 4'b0001, n: 4'd1, ids: 32'h0000_0000};
        vecs[2] = '{req: 4'b1010, n: 4'd4, ids: 32'h0000_3131};
        vecs[3] = '{req: 4'b0100, n: 4'd2, ids: 32'h0000_0022};
        vecs[4] = '{req: 4'b1001, n: 4'd3, ids: 32'h0000_0303};
        vecs[5] = '{req: 4'b0110, n: 4'd3, ids: 32'h0000_0121};

        do_reset();

        for (int v = 0; v < 6; v++) run_vec(vecs[v].req, int'(vecs[v].n), vecs[v].ids);

        // spurious last-stage edge with nothing in flight is ignored
        s0 = pipe_sink;
        pipe_ackn = ~pipe_ackn;
        repeat (8) step();
        chk(pipe_sink == s0, "spurious_sink", int'(pipe_sink), int'(s0));
        chk(inflight_o == 2'd0, "spurious_inflight", int'(inflight_o), 0);
        pipe_ackn = ~pipe_ackn;
        repeat (4) step();

        // sink stalled: exactly DEPTH grants, then blocked until a completion
        vexp.delete();
        vexp.push_back(0); vexp.push_back(1); vexp.push_back(0);
        vexp.push_back(1); vexp.push_back(0);
        stall = 1'b1;
        g0 = gcount;
        req_i = 4'b0011;
        repeat (60) step();
        chk((gcount - g0) == 3, "stall_grants", gcount - g0, 3);
        chk(inflight_o == 2'd3, "stall_inflight", int'(inflight_o), 3);
        stall = 1'b0;
        for (int c = 0; c < 300 && (gcount - g0) < 5; c++) step();
        req_i = '0;
        chk((gcount - g0) == 5, "unstall_grants", gcount - g0, 5);
        drain("stall_drain");

        // reset with tokens in flight discards them without completions
        req_i = 4'b1111;
        for (int c = 0; c < 200 && mq.size() < 2; c++) step();
        chk(mq.size() >= 2, "midop_fill", mq.size(), 2);
        do_reset();
        repeat (20) step();
        run_vec(4'b0100, 1, 32'h2);

        // randomised traffic with random sink stalls
        auto_clear = 1'b1;
        gen_new = 1'b1;
        repeat (1500) step();
        gen_new = 1'b0;
        stall = 1'b0;
        drain("random_drain");
        chk(req_i == 4'b0, "random_all_granted", int'(req_i), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
